fb_draw_writer: RTL and testbench

- Downstream consumer of the sprite/layer renderer's pixel-draw stream (Draw_X, Draw_Y, Draw_Color, Enable_Draw).
- Clips and serialises each draw into the back bank of a double-buffered 160x120, 9-bit framebuffer, and clears that bank with a background colour before each frame.
- Serves the front bank to the VGA scan-out through a 1-cycle-latency read port.
- Swaps banks on a frame-end request, synchronised to vsync.

---
 rtl/fb_draw_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_fb_draw_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_draw_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_draw_writer
// Purpose  : Clips and writes the renderer's pixel-draw stream into the back
//            bank of a double-buffered framebuffer. Clears the back bank with
//            a background colour before each frame. Serves the front bank to
//            scan-out through a registered read port. Swaps banks on
//            frame_end, aligned to vsync.
// Revision : 1.0  initial release
// ============================================================================
module fb_draw_writer #(
  parameter int                       FB_WIDTH      = 160,
  parameter int                       FB_HEIGHT     = 120,
  parameter int                       FB_COLOR_BITS = 9,
  parameter int                       FB_WORDS      = 19200,
  parameter int                       FB_ADDRW      = 15,
  parameter logic [FB_COLOR_BITS-1:0] BG_COLOR      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              Draw_X,
  input  logic [31:0]              Draw_Y,
  input  logic [31:0]              Draw_Color,
  input  logic                     Enable_Draw,
  input  logic                     frame_end,
  input  logic                     vsync,
  input  logic [FB_ADDRW-1:0]      rd_addr,
  output logic [FB_COLOR_BITS-1:0] rd_data,
  output logic                     front_sel,
  output logic                     busy_clear,
  output logic [15:0]              drop_count,
  output logic [15:0]              clip_count
);

  localparam logic [FB_ADDRW-1:0] C_LAST_ADDR = FB_ADDRW'(FB_WORDS - 1);
  localparam logic [FB_ADDRW-1:0] C_WORDS     = FB_ADDRW'(FB_WORDS);
  localparam logic [31:0]         C_WIDTH     = 32'(FB_WIDTH);
  localparam logic [31:0]         C_HEIGHT    = 32'(FB_HEIGHT);
  localparam logic [15:0]         C_CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_CLEAR      = 2'd0,
    ST_DRAW       = 2'd1,
    ST_WAIT_VSYNC = 2'd2
  } state_t;

  // Control state
  state_t                  state_q,    state_d;
  logic [FB_ADDRW-1:0]     clr_addr_q, clr_addr_d;
  logic                    pend_q,     pend_d;
  logic                    front_q,    front_d;
  logic                    clr_we;

  // Draw pipeline stage 1 (stage 2 is the bank write itself)
  logic                     s1_valid_q;
  logic [FB_ADDRW-1:0]      s1_addr_q;
  logic [FB_COLOR_BITS-1:0] s1_color_q;
  logic                     s1_bank_q;

  // Counters
  logic [15:0] drop_q;
  logic [15:0] clip_q;

  // Read port control
  logic                     rd_sel_q;
  logic                     rd_zero_q;
  logic [FB_COLOR_BITS-1:0] bank_rd [2];

  // Draw qualification
  logic        in_range;
  logic        busy;
  logic        accept;
  logic        drop_hit;
  logic        clip_hit;
  logic [31:0] addr_full;
  logic        unused_bits;

  assign busy      = (state_q == ST_CLEAR);
  assign in_range  = (Draw_X < C_WIDTH) && (Draw_Y < C_HEIGHT);
  assign accept    = Enable_Draw && !busy && in_range;
  assign drop_hit  = Enable_Draw && busy;
  assign clip_hit  = Enable_Draw && !busy && !in_range;
  // y*160 + x expressed as shifts so no multiplier is needed
  assign addr_full = (Draw_Y << 7) + (Draw_Y << 5) + Draw_X;

  // Colour upper bits and the high address bits are intentionally ignored
  assign unused_bits = ^{Draw_Color[31:FB_COLOR_BITS], addr_full[31:FB_ADDRW]};

  // Next-state logic for the clear / draw / wait-for-vsync sequencer
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    pend_d     = pend_q;
    front_d    = front_q;
    clr_we     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (frame_end) begin
          pend_d = 1'b1;
        end
        if (clr_addr_q == C_LAST_ADDR) begin
          clr_addr_d = '0;
          // A swap requested during the clear goes straight to waiting for vsync
          if (pend_q || frame_end) begin
            state_d = ST_WAIT_VSYNC;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_DRAW;
          end
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_DRAW: begin
        if (frame_end) begin
          state_d = ST_WAIT_VSYNC;
        end
      end
      ST_WAIT_VSYNC: begin
        // Toggle and clear start together; the first clear write lands one cycle later
        if (vsync) begin
          front_d = ~front_q;
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      pend_q     <= 1'b0;
      front_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pend_q     <= pend_d;
      front_q    <= front_d;
    end
  end

  // Stage 1: capture a qualified draw, including the bank it targets
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_color_q <= '0;
      s1_bank_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_addr_q  <= addr_full[FB_ADDRW-1:0];
      s1_color_q <= Draw_Color[FB_COLOR_BITS-1:0];
      s1_bank_q  <= ~front_q;
    end
  end

  // Saturating loss counters; a draw lost to the clear is never also a clip
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      clip_q <= '0;
    end else begin
      if (drop_hit && (drop_q != C_CNT_MAX)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (clip_hit && (clip_q != C_CNT_MAX)) begin
        clip_q <= clip_q + 16'd1;
      end
    end
  end

  // Read-side bookkeeping: which bank feeds rd_data and whether to force zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel_q  <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      rd_sel_q  <= front_q;
      rd_zero_q <= (rd_addr >= C_WORDS);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [FB_COLOR_BITS-1:0] mem_q [FB_WORDS];
    logic [FB_COLOR_BITS-1:0] rd_q;
    logic                     clr_hit;
    logic                     drw_hit;
    logic                     we;
    logic [FB_ADDRW-1:0]      waddr;
    logic [FB_COLOR_BITS-1:0] wdata;

    // Clear and draw never target the same bank in the same cycle
    assign clr_hit = clr_we && (~front_q == 1'(b));
    assign drw_hit = s1_valid_q && (s1_bank_q == 1'(b));
    assign we      = !reset && (clr_hit || drw_hit);
    assign waddr   = clr_hit ? clr_addr_q : s1_addr_q;
    assign wdata   = clr_hit ? BG_COLOR   : s1_color_q;

    // Single write port per bank
    always_ff @(posedge clk) begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
    end

    // Registered read port per bank; out-of-range reads are masked downstream
    always_ff @(posedge clk) begin
      rd_q <= mem_q[rd_addr];
    end

    assign bank_rd[b] = rd_q;
  end

  assign rd_data    = rd_zero_q ? '0 : bank_rd[rd_sel_q];
  assign front_sel  = front_q;
  assign busy_clear = busy;
  assign drop_count = drop_q;
  assign clip_count = clip_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_draw_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_draw_writer
// Purpose  : Self-checking bench for fb_draw_writer using a queue of expected
//            framebuffer words that is drained through the read port.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_draw_writer;

  localparam int C_WORDS = 19200;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Draw_X;
  logic [31:0] Draw_Y;
  logic [31:0] Draw_Color;
  logic        Enable_Draw;
  logic        frame_end;
  logic        vsync;
  logic [14:0] rd_addr;
  logic [8:0]  rd_data;
  logic        front_sel;
  logic        busy_clear;
  logic [15:0] drop_count;
  logic [15:0] clip_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  typedef struct {
    logic [14:0] addr;
    logic [8:0]  data;
  } exp_t;

  exp_t sb[$];

  fb_draw_writer dut (
    .clk        (clk),
    .reset      (reset),
    .Draw_X     (Draw_X),
    .Draw_Y     (Draw_Y),
    .Draw_Color (Draw_Color),
    .Enable_Draw(Enable_Draw),
    .frame_end  (frame_end),
    .vsync      (vsync),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .front_sel  (front_sel),
    .busy_clear (busy_clear),
    .drop_count (drop_count),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus helpers (drive at negedge, return on the following negedge)
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input int addr, input logic [8:0] data);
    exp_t e;
    e.addr = 15'(addr);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic draw(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    Enable_Draw = 1'b1;
    Draw_X      = x;
    Draw_Y      = y;
    Draw_Color  = c;
    @(negedge clk);
    Enable_Draw = 1'b0;
  endtask

  // Draw an in-range pixel and record what the bank should hold afterwards
  task automatic draw_px(input int x, input int y, input logic [31:0] c);
    expect_word(y * 160 + x, c[8:0]);
    draw(32'(x), 32'(y), c);
  endtask

  task automatic read_word(input logic [14:0] addr, output logic [8:0] data);
    rd_addr = addr;
    @(negedge clk);
    data = rd_data;
  endtask

  task automatic wait_clear(output bit ok);
    int n;
    n = 0;
    while (busy_clear && n < 20100) begin
      @(negedge clk);
      n++;
    end
    ok = !busy_clear;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    n_cmp++; if (front_sel !== 1'b0) begin n_bad++; $display("FAIL rst_front: got %0b want 0", front_sel); end
    n_cmp++; if (rd_data !== 9'h000) begin n_bad++; $display("FAIL rst_rd_data: got %h want 000", rd_data); end
    n_cmp++; if (busy_clear !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %0b want 1", busy_clear); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
    n_cmp++; if (clip_count !== 16'd0) begin n_bad++; $display("FAIL rst_clip: got %0d want 0", clip_count); end
    reset = 1'b0;
    t0    = cyc;
  endtask

  // Every strobe during the clear is dropped; odd ones are also out of range
  task automatic test_drop_during_clear();
    for (int i = 0; i < 100; i++) begin
      draw((i % 2 == 1) ? 32'd500 : 32'(i), 32'd7, 32'(i));
    end
    n_cmp++; if (drop_count !== 16'd100) begin n_bad++; $display("FAIL drop_cnt: got %0d want 100", drop_count); end
    n_cmp++; if (clip_count !== 16'd0) begin n_bad++; $display("FAIL drop_prec_clip: got %0d want 0", clip_count); end
    n_cmp++; if (busy_clear !== 1'b1) begin n_bad++; $display("FAIL drop_busy: got %0b want 1", busy_clear); end
  endtask

  task automatic test_clear_timing();
    bit ok;
    wait_clear(ok);
    n_cmp++;
    if (!ok || (cyc - t0) != C_WORDS) begin
      n_bad++; $display("FAIL clear_len: got %0d cycles (done=%0b) want %0d", cyc - t0, ok, C_WORDS);
    end
    n_cmp++; if (drop_count !== 16'd100) begin n_bad++; $display("FAIL post_clear_drop: got %0d want 100", drop_count); end
  endtask

  task automatic test_draw_and_swap();
    exp_t        e;
    logic [8:0]  got;
    n_cmp++; if (front_sel !== 1'b0) begin n_bad++; $display("FAIL pre_swap_front: got %0b want 0", front_sel); end
    // Back-to-back in-range draws
    draw_px(5,   3,   32'h0000_01AB);
    draw_px(10,  20,  32'hABCD_E0F0);
    draw_px(158, 119, 32'h0000_0123);
    draw_px(1,   0,   32'h0000_01C3);
    // Out-of-range draws: neighbours and the wrapped address must stay background
    draw(32'd160, 32'd0, 32'h1FF);
    draw(32'd0, 32'hFFFF_FFFF, 32'h1FF);
    expect_word(159, 9'h000);
    expect_word(160, 9'h000);
    expect_word(19199, 9'h000);
    expect_word(0, 9'h000);
    expect_word(19200, 9'h000);
    expect_word(32767, 9'h000);
    n_cmp++; if (clip_count !== 16'd2) begin n_bad++; $display("FAIL clip_cnt: got %0d want 2", clip_count); end
    // vsync before frame_end does nothing
    vsync = 1'b1; step(1); vsync = 1'b0; step(1);
    n_cmp++; if (front_sel !== 1'b0 || busy_clear !== 1'b0) begin
      n_bad++; $display("FAIL vsync_in_draw: front=%0b busy=%0b want 0 0", front_sel, busy_clear);
    end
    frame_end = 1'b1; step(1); frame_end = 1'b0; step(2);
    frame_end = 1'b1; step(1); frame_end = 1'b0; step(1);
    n_cmp++; if (front_sel !== 1'b0) begin n_bad++; $display("FAIL wait_front: got %0b want 0", front_sel); end
    vsync = 1'b1; step(1); vsync = 1'b0;
    t0 = cyc;
    n_cmp++; if (front_sel !== 1'b1 || busy_clear !== 1'b1) begin
      n_bad++; $display("FAIL swap1: front=%0b busy=%0b want 1 1", front_sel, busy_clear);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_word(e.addr, got);
      n_cmp++; if (got !== e.data) begin n_bad++; $display("FAIL rd_swap1 addr %0d: got %h want %h", e.addr, got, e.data); end
    end
  endtask

  task automatic test_reset_inflight();
    bit         ok;
    exp_t       e;
    logic [8:0] got;
    wait_clear(ok);
    n_cmp++;
    if (!ok || (cyc - t0) != C_WORDS) begin
      n_bad++; $display("FAIL clear2_len: got %0d cycles (done=%0b) want %0d", cyc - t0, ok, C_WORDS);
    end
    read_word(15'd485, got);
    n_cmp++; if (got !== 9'h1AB) begin n_bad++; $display("FAIL pre_rst_rd: got %h want 1ab", got); end
    // Draw into bank 0, then reset while the write is still in stage 1
    Enable_Draw = 1'b1; Draw_X = 32'd20; Draw_Y = 32'd10; Draw_Color = 32'h155;
    step(1);
    Enable_Draw = 1'b0;
    reset = 1'b1;
    step(1);
    n_cmp++; if (front_sel !== 1'b0) begin n_bad++; $display("FAIL mid_rst_front: got %0b want 0", front_sel); end
    n_cmp++; if (busy_clear !== 1'b1) begin n_bad++; $display("FAIL mid_rst_busy: got %0b want 1", busy_clear); end
    n_cmp++; if (drop_count !== 16'd0 || clip_count !== 16'd0) begin
      n_bad++; $display("FAIL mid_rst_cnt: drop=%0d clip=%0d want 0 0", drop_count, clip_count);
    end
    n_cmp++; if (rd_data !== 9'h000) begin n_bad++; $display("FAIL mid_rst_rd: got %h want 000", rd_data); end
    reset = 1'b0;
    t0    = cyc;
    expect_word(10 * 160 + 20, 9'h000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_word(e.addr, got);
      n_cmp++; if (got !== e.data) begin n_bad++; $display("FAIL inflight_gone addr %0d: got %h want %h", e.addr, got, e.data); end
    end
  endtask

  task automatic test_pending_swap();
    bit         ok;
    exp_t       e;
    logic [8:0] got;
    step(50);
    frame_end = 1'b1; step(1); frame_end = 1'b0;
    step(20);
    vsync = 1'b1; step(1); vsync = 1'b0; step(100);
    vsync = 1'b1; step(1); vsync = 1'b0; step(1);
    n_cmp++; if (front_sel !== 1'b0) begin n_bad++; $display("FAIL vsync_in_clear: got %0b want 0", front_sel); end
    wait_clear(ok);
    n_cmp++;
    if (!ok || (cyc - t0) != C_WORDS) begin
      n_bad++; $display("FAIL clear3_len: got %0d cycles (done=%0b) want %0d", cyc - t0, ok, C_WORDS);
    end
    // Draws are still accepted while waiting for vsync
    draw_px(30, 40, 32'h0AA);
    rd_addr = 15'd1620;
    step(1);
    n_cmp++; if (rd_data !== 9'h000) begin n_bad++; $display("FAIL inflight_after_clear: got %h want 000", rd_data); end
    step(8);
    n_cmp++; if (front_sel !== 1'b0) begin n_bad++; $display("FAIL pend_hold_front: got %0b want 0", front_sel); end
    vsync = 1'b1; step(1); vsync = 1'b0;
    n_cmp++; if (front_sel !== 1'b1) begin n_bad++; $display("FAIL pend_swap: got %0b want 1", front_sel); end
    step(3);
    n_cmp++; if (front_sel !== 1'b1 || busy_clear !== 1'b1) begin
      n_bad++; $display("FAIL pend_once: front=%0b busy=%0b want 1 1", front_sel, busy_clear);
    end
    expect_word(485, 9'h000);
    expect_word(1620, 9'h000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_word(e.addr, got);
      n_cmp++; if (got !== e.data) begin n_bad++; $display("FAIL rd_swap2 addr %0d: got %h want %h", e.addr, got, e.data); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    Draw_X      = '0;
    Draw_Y      = '0;
    Draw_Color  = '0;
    Enable_Draw = 1'b0;
    frame_end   = 1'b0;
    vsync       = 1'b0;
    rd_addr     = '0;
    test_reset();
    test_drop_during_clear();
    test_clear_timing();
    test_draw_and_swap();
    test_reset_inflight();
    test_pending_swap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
